flash_boot_ctrl: RTL

FLASH_BOOT_CTRL -- requirements
Module: flash_boot_ctrl

---
 rtl/flash_boot_ctrl_if.sv | 30 +++
 rtl/flash_boot_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/flash_boot_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | flash_boot_ctrl_if : SPI flash, imem write and core-control bundle    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface flash_boot_ctrl_if;
  logic        o_flash_sclk;
  logic        o_flash_cs_n;
  logic        o_flash_mosi;
  logic        i_flash_miso;
  logic        o_imem_we;
  logic [31:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        i_imem_ack;
  logic        o_core_rst;
  logic        o_done;

  modport master (
    output o_flash_sclk, o_flash_cs_n, o_flash_mosi, o_imem_we,
           o_imem_addr, o_imem_wdata, o_core_rst, o_done,
    input  i_flash_miso, i_imem_ack
  );

  modport slave (
    input  o_flash_sclk, o_flash_cs_n, o_flash_mosi, o_imem_we,
           o_imem_addr, o_imem_wdata, o_core_rst, o_done,
    output i_flash_miso, i_imem_ack
  );
endinterface
`default_nettype wire

// File: rtl/flash_boot_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | flash_boot_ctrl : copies a boot image from SPI flash into imem, then  |
// | releases the core from reset.                        Rev 1.0          |
// +-----------------------------------------------------------------------+
module flash_boot_ctrl #(
  parameter logic [23:0] BOOT_ADDR = 24'h000000,
  parameter int unsigned WORDS     = 1024,
  parameter int unsigned CLK_DIV   = 2
) (
  input wire logic          clk,
  input wire logic          reset,
  flash_boot_ctrl_if.master bus
);

  localparam int unsigned c_div_w  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned c_word_w = $clog2(WORDS + 1);
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
  localparam logic [c_word_w-1:0] c_word_last = c_word_w'(WORDS - 1);
  localparam logic [31:0]         c_cmd       = {8'h03, BOOT_ADDR};

  typedef enum logic [1:0] {
    S_CMD   = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_sclk;
  logic                r_cs_n;
  logic                r_mosi;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic                r_core_rst;
  logic                r_done;
  logic [c_div_w-1:0]  r_div;
  logic [4:0]          r_bit;
  logic [c_word_w-1:0] r_word;
  logic [31:0]         r_tx;
  logic [31:0]         r_rx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_CMD;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_div      <= '0;
      r_bit      <= 5'd0;
      r_word     <= '0;
      r_tx       <= 32'd0;
      r_rx       <= 32'd0;
    end else begin
      case (r_state)
        S_CMD, S_DATA: begin
          if (r_cs_n) begin
            // First cycle out of reset: select the flash and present the opcode MSB.
            r_cs_n <= 1'b0;
            r_mosi <= c_cmd[31];
            r_tx   <= {c_cmd[30:0], 1'b0};
            r_div  <= '0;
            r_bit  <= 5'd0;
          end else if (r_div == c_div_last) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              if (r_state == S_DATA) begin
                r_rx <= {r_rx[30:0], bus.i_flash_miso};
              end
            end else if (r_bit == 5'd31) begin
              r_bit <= 5'd0;
              if (r_state == S_CMD) begin
                r_state <= S_DATA;
                r_mosi  <= 1'b0;
              end else begin
                // Stream arrives byte 0 first; byte 0 belongs in the low lane.
                r_state <= S_WRITE;
                r_we    <= 1'b1;
                r_wdata <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
              end
            end else begin
              r_bit <= r_bit + 5'd1;
              if (r_state == S_CMD) begin
                r_mosi <= r_tx[31];
                r_tx   <= {r_tx[30:0], 1'b0};
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_WRITE: begin
          // SCLK parked low and cs_n kept low so the flash read continues after the stall.
          if (bus.i_imem_ack) begin
            r_we   <= 1'b0;
            r_addr <= r_addr + 32'd4;
            if (r_word == c_word_last) begin
              r_state    <= S_DONE;
              r_cs_n     <= 1'b1;
              r_core_rst <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_word  <= r_word + 1'b1;
              r_state <= S_DATA;
              r_div   <= '0;
            end
          end
        end

        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

  assign bus.o_flash_sclk = r_sclk;
  assign bus.o_flash_cs_n = r_cs_n;
  assign bus.o_flash_mosi = r_mosi;
  assign bus.o_imem_we    = r_we;
  assign bus.o_imem_addr  = r_addr;
  assign bus.o_imem_wdata = r_wdata;
  assign bus.o_core_rst   = r_core_rst;
  assign bus.o_done       = r_done;

endmodule
`default_nettype wire
